// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and constants for the serial sum collector
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must be able to hold the value WIDTH itself
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_sum_collector_if.sv
// rtl/sipo_sum_collector_if.sv - parallel result channel with valid/ready handshake
interface sipo_sum_collector_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] result;
  logic             cout;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output result,
    output cout,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  result,
    input  cout,
    input  res_valid,
    output res_ready
  );

endinterface

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - right-shifting serial-in register, new bits enter at the MSB
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (shift_en) begin
      word <= {bit_in, word[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_sum_collector.sv
// rtl/sipo_sum_collector.sv - collects an LSB-first sum stream and hands off word plus carry
module sipo_sum_collector
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic carry_in,
  output logic busy,
  output logic overrun,
  sipo_sum_collector_if.master res
);

  localparam int            CW   = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             accept;
  logic             clear;
  logic             shift_en;

  assign accept   = (state == DONE) && res.res_ready;
  // start wins over a same-cycle bit, so an aborted word never keeps a stray bit
  assign clear    = start && ((state == IDLE) || (state == SHIFT) || accept);
  assign shift_en = (state == SHIFT) && bit_valid && !start;
  assign shifted  = {bit_in, word[WIDTH-1:1]};

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (shift_en),
    .bit_in   (bit_in),
    .word     (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      overrun  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SHIFT;
            count   <= '0;
            overrun <= 1'b0;
          end
        end
        SHIFT: begin
          if (start) begin
            count   <= '0;
            overrun <= 1'b0;
          end else if (bit_valid) begin
            if (count != FULL) begin
              count <= count + CW'(1);
            end
            if (count == LAST) begin
              state    <= DONE;
              result_q <= shifted;
              cout_q   <= carry_in;
            end
          end
        end
        DONE: begin
          if (bit_valid) begin
            overrun <= 1'b1;
          end
          if (res.res_ready) begin
            if (start) begin
              state   <= SHIFT;
              count   <= '0;
              overrun <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy          = (state == SHIFT);
  assign res.res_valid = (state == DONE);
  assign res.result    = result_q;
  assign res.cout      = cout_q;

endmodule

// File: tb/tb_sipo_sum_collector.sv
// tb/tb_sipo_sum_collector.sv - randomized self-checking bench for sipo_sum_collector
module tb_sipo_sum_collector;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic carry_in = 1'b0;
  logic busy;
  logic overrun;

  int checks = 0;
  int errors = 0;

  sipo_sum_collector_if #(.WIDTH(W)) rif ();

  sipo_sum_collector #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .carry_in  (carry_in),
    .busy      (busy),
    .overrun   (overrun),
    .res       (rif)
  );

  always #5 clk = ~clk;

  // Reference: the k-th received bit carries weight 2**k
  function automatic logic [W-1:0] model_pack(input logic q[$]);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < q.size() && i < W; i++) begin
      if (q[i]) w = w + (W'(1) << i);
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic c);
    bit_in    = b;
    carry_in  = c;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    carry_in  = 1'b0;
  endtask

  task automatic accept();
    rif.res_ready = 1'b1;
    tick();
    rif.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (rif.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", rif.res_valid); end
    checks++; if (rif.result !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", rif.result); end
    checks++; if (busy !== 1'b0 || overrun !== 1'b0 || rif.cout !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b ovr=%b cout=%b exp 0", busy, overrun, rif.cout);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_contiguous();
    logic q[$];
    logic [7:0] w;
    w = 8'hB3;
    do_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL contig_busy got %b exp 1", busy); end
    for (int i = 0; i < W; i++) begin
      q.push_back(w[i]);
      send_bit(w[i], i == W - 1);
      if (i == W - 2) begin
        checks++; if (rif.res_valid !== 1'b0) begin errors++; $display("FAIL contig_early_valid got %b exp 0", rif.res_valid); end
      end
    end
    checks++; if (rif.res_valid !== 1'b1) begin errors++; $display("FAIL contig_valid got %b exp 1", rif.res_valid); end
    checks++; if (rif.result !== model_pack(q)) begin errors++; $display("FAIL contig_result got %h exp %h", rif.result, model_pack(q)); end
    checks++; if (rif.cout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL contig_cout_busy got cout=%b busy=%b exp 1/0", rif.cout, busy); end
    accept();
    checks++; if (rif.res_valid !== 1'b0) begin errors++; $display("FAIL contig_drop got %b exp 0", rif.res_valid); end
  endtask

  task automatic test_gaps();
    logic q[$];
    logic [7:0] w;
    w = 8'h5A;
    do_start();
    for (int i = 0; i < W; i++) begin
      q.push_back(w[i]);
      send_bit(w[i], 1'b0);
      if (i < W - 1) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
        checks++; if (busy !== 1'b1 || rif.res_valid !== 1'b0) begin
          errors++; $display("FAIL gaps_state got busy=%b valid=%b exp 1/0", busy, rif.res_valid);
        end
      end
    end
    checks++; if (rif.result !== model_pack(q) || rif.res_valid !== 1'b1) begin
      errors++; $display("FAIL gaps_result got %h/%b exp %h/1", rif.result, rif.res_valid, model_pack(q));
    end
    accept();
  endtask

  task automatic test_backpressure();
    logic q[$];
    logic c;
    logic [W-1:0] exp;
    c = 1'($urandom);
    do_start();
    for (int i = 0; i < W; i++) begin
      q.push_back(1'($urandom));
      send_bit(q[i], (i == W - 1) ? c : 1'b0);
    end
    exp = model_pack(q);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) send_bit(~q[0], ~c);
      else tick();
      checks++; if (rif.result !== exp || rif.cout !== c || rif.res_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold got %h/%b/%b exp %h/%b/1", rif.result, rif.cout, rif.res_valid, exp, c);
      end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b exp 1", overrun); end
    accept();
    checks++; if (rif.res_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL bp_accept got valid=%b ovr=%b exp 0/1", rif.res_valid, overrun);
    end
  endtask

  task automatic test_abort();
    logic [3:0] pre;
    pre = 4'b0010;
    do_start();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL abort_ovr_clear got %b exp 0", overrun); end
    for (int i = 0; i < 4; i++) send_bit(pre[i], 1'b0);
    start = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    tick();
    start = 1'b0; bit_valid = 1'b0;
    for (int i = 0; i < W; i++) send_bit(1'b1, 1'b0);
    checks++; if (rif.result !== 8'hFF || rif.cout !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL abort_result got %h/%b/%b exp ff/0/0", rif.result, rif.cout, overrun);
    end
    accept();
  endtask

  task automatic test_async_reset();
    do_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rif.result !== 8'h00 || rif.res_valid !== 1'b0 || overrun !== 1'b0 || rif.cout !== 1'b0) begin
      errors++; $display("FAIL async_rst got busy=%b res=%h valid=%b exp 0/00/0", busy, rif.result, rif.res_valid);
    end
    #1 rst = 1'b0;
    tick();
    do_start();
    for (int i = 0; i < W; i++) send_bit(i == 0, 1'b0);
    checks++; if (rif.result !== 8'h01 || rif.res_valid !== 1'b1) begin
      errors++; $display("FAIL async_fresh got %h/%b exp 01/1", rif.result, rif.res_valid);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    a = 8'h0F;
    b = 8'hF0;
    rif.res_ready = 1'b1;
    do_start();
    for (int i = 0; i < W; i++) send_bit(a[i], 1'b0);
    checks++; if (rif.result !== a || rif.res_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first got %h/%b exp %h/1", rif.result, rif.res_valid, a);
    end
    do_start();
    checks++; if (rif.res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_rearm got valid=%b busy=%b exp 0/1", rif.res_valid, busy);
    end
    for (int i = 0; i < W; i++) send_bit(b[i], 1'b1);
    checks++; if (rif.result !== b || rif.res_valid !== 1'b1 || rif.cout !== 1'b1) begin
      errors++; $display("FAIL b2b_second got %h/%b/%b exp %h/1/1", rif.result, rif.res_valid, rif.cout, b);
    end
    tick();
    checks++; if (rif.res_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_end got valid=%b busy=%b ovr=%b exp 0/0/0", rif.res_valid, busy, overrun);
    end
    rif.res_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic q[$];
      logic c;
      c = 1'($urandom);
      do_start();
      for (int i = 0; i < W; i++) begin
        q.push_back(1'($urandom));
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        send_bit(q[i], (i == W - 1) ? c : 1'b0);
      end
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
      checks++; if (rif.result !== model_pack(q) || rif.cout !== c || rif.res_valid !== 1'b1) begin
        errors++; $display("FAIL rand_%0d got %h/%b/%b exp %h/%b/1", n, rif.result, rif.cout, rif.res_valid, model_pack(q), c);
      end
      accept();
      checks++; if (rif.res_valid !== 1'b0) begin errors++; $display("FAIL rand_drop_%0d got %b exp 0", n, rif.res_valid); end
    end
  endtask

  initial begin
    rif.res_ready = 1'b0;
    test_reset();
    test_contiguous();
    test_gaps();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
